chronospatial_host: RTL

Host-side driver for the chronospatial 3-bit computer core. It sits on the other side of the core's `ui_in`/`uo_out` pins. It holds the program image and the initial A/B/C register values. On `start` it serially shifts the register values into the core, then serves opcode/operand pairs addressed by the core's instruction pointer. It captures every 3-bit output value into a FIFO for the downstream consumer and reports completion when the core halts.

---
 rtl/chronospatial_pkg.sv | 39 +++
 rtl/chronospatial_out_fifo.sv | 45 ++++
 rtl/chronospatial_host.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/chronospatial_pkg.sv
// Shared definitions for the chronospatial host driver: core pin field positions,
// FSM state encoding and the helpers that build core_ui_in words.
package chronospatial_pkg;

    localparam int OPC_W       = 3;
    localparam int UI_INIT_BIT = 3;
    localparam int UI_OPND_LSB = 4;
    localparam int UO_VAL_LSB  = 0;
    localparam int UO_OUTV_BIT = 3;
    localparam int UO_HALT_BIT = 4;
    localparam int UO_IP_LSB   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [7:0] init_word(input logic a, input logic b, input logic c);
        logic [7:0] w;
        w              = '0;
        w[0]           = a;
        w[1]           = b;
        w[2]           = c;
        w[UI_INIT_BIT] = 1'b1;
        return w;
    endfunction

    // A program slot is {opcode, operand}; the core expects opcode low, operand high.
    function automatic logic [7:0] run_word(input logic [5:0] slot);
        logic [7:0] w;
        w                         = '0;
        w[OPC_W-1:0]              = slot[5:3];
        w[UI_OPND_LSB +: OPC_W]   = slot[2:0];
        return w;
    endfunction

endpackage

// File: rtl/chronospatial_out_fifo.sv
// Synchronous FIFO for captured core output values. Extra pointer MSB separates
// full from empty; a push on a full FIFO is accepted when a pop happens that cycle.
module chronospatial_out_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_fire;
    logic         rd_fire;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_fire = push && (!full || pop);
    assign rd_fire = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/chronospatial_host.sv
// Host driver for the chronospatial core: seeds A/B/C serially, serves program
// slots by instruction pointer, and queues core output values for a consumer.
module chronospatial_host
    import chronospatial_pkg::*;
#(
    parameter int REG_W      = 24,
    parameter int OUT_DEPTH  = 8,
    parameter int MAX_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_wr_en,
    input  logic [2:0]       prog_wr_addr,
    input  logic [5:0]       prog_wr_data,
    input  logic [REG_W-1:0] seed_a,
    input  logic [REG_W-1:0] seed_b,
    input  logic [REG_W-1:0] seed_c,
    input  logic             start,
    output logic [7:0]       core_ui_in,
    input  logic [7:0]       core_uo_out,
    output logic [2:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             timeout
);

    localparam int CNT_W = $clog2(REG_W + 1);
    localparam int WD_W  = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG_W);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_CYCLES - 1);

    state_t           state, state_nxt;
    logic [REG_W-1:0] sh_a, sh_b, sh_c;
    logic [CNT_W-1:0] bit_cnt;
    logic [WD_W-1:0]  wdog;
    logic [5:0]       prog_mem [8];

    logic [2:0] ip;
    logic [2:0] core_val;
    logic       core_halt;
    logic       core_ov;
    logic       idle_like;
    logic       start_ok;
    logic       init_last;
    logic       wd_expire;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic [7:0] run_drive;

    assign ip        = core_uo_out[UO_IP_LSB +: 3];
    assign core_val  = core_uo_out[UO_VAL_LSB +: 3];
    assign core_halt = core_uo_out[UO_HALT_BIT];
    assign core_ov   = core_uo_out[UO_OUTV_BIT];

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok  = idle_like && start;
    assign init_last = (bit_cnt == LAST_BIT);
    assign wd_expire = (wdog == WD_LAST);
    assign run_drive = run_word(prog_mem[ip]);

    // Consumer handshake: out_valid means the head is stable in out_data; the head
    // is consumed on any cycle where out_valid && out_ready. out_valid never
    // depends combinationally on out_ready.
    assign push      = (state == ST_RUN) && core_ov;
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;

    assign busy = (state == ST_INIT) || (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_INIT;
            ST_INIT:          if (init_last) state_nxt = ST_RUN;
            ST_RUN:           if (core_halt || wd_expire) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // The first seed bit goes out on the start edge itself, so the shifters load
    // already advanced by one and the bit counter starts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ui_in <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_c       <= '0;
            bit_cnt    <= '0;
            wdog       <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else if (start_ok) begin
            core_ui_in <= init_word(seed_a[0], seed_b[0], seed_c[0]);
            sh_a       <= seed_a >> 1;
            sh_b       <= seed_b >> 1;
            sh_c       <= seed_c >> 1;
            bit_cnt    <= CNT_W'(1);
            wdog       <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_last) begin
                        core_ui_in <= run_drive;
                    end else begin
                        core_ui_in <= init_word(sh_a[0], sh_b[0], sh_c[0]);
                        sh_a       <= sh_a >> 1;
                        sh_b       <= sh_b >> 1;
                        sh_c       <= sh_c >> 1;
                        bit_cnt    <= bit_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (core_ov && full && !pop) overflow <= 1'b1;
                    if (core_halt) begin
                        core_ui_in <= '0;
                    end else if (wd_expire) begin
                        core_ui_in <= '0;
                        timeout    <= 1'b1;
                    end else begin
                        core_ui_in <= run_drive;
                        wdog       <= wdog + 1'b1;
                    end
                end
                default: core_ui_in <= '0;
            endcase
        end
    end

    // Program image survives reset; writes are only honoured while no run is active.
    always_ff @(posedge clk) begin
        if (prog_wr_en && idle_like) prog_mem[prog_wr_addr] <= prog_wr_data;
    end

    chronospatial_out_fifo #(
        .W     (3),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (core_val),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty)
    );

endmodule
